// File: rtl/spdif_bmc_decoder.sv
// spdif_bmc_decoder
// Biphase-mark (S/PDIF) subframe decoder. The input is sampled once per
// half-cell on clk128, and each sample is reduced to a transition flag.
// The decoder finds the B/M/W preambles, checks the mandatory cell-boundary
// transitions, and collects the 28 data slots. It presents each subframe on
// a valid/ready output register set.
//
// Build option: define SPDIF_DECODER_PARITY_CHECK_EN to build the even-parity
// check over slots 4..31. Without it, o_parity_error is tied low.
module spdif_bmc_decoder #(
    parameter int LOCK_COUNT = 2
) (
    input  logic        clk128,
    input  logic        reset,
    input  logic        i_bmc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [23:0] o_data,
    output logic        o_v,
    output logic        o_u,
    output logic        o_c,
    output logic [1:0]  o_preamble,
    output logic        o_parity_error,
    output logic        o_bmc_error,
    output logic        o_overrun,
    output logic        o_locked
);

    // Preamble transition patterns, oldest flag in bit 7.
    localparam logic [7:0] PAT_B     = 8'b1001_1100;
    localparam logic [7:0] PAT_M     = 8'b1001_0011;
    localparam logic [7:0] PAT_W     = 8'b1001_0110;
    localparam logic [3:0] LOCK_MAX  = 4'(LOCK_COUNT);
    localparam logic [5:0] LAST_HALF = 6'd55;
    localparam logic [5:0] SYNC_LAST = 6'd7;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        SYNC = 2'd2
    } state_t;

    state_t      state_reg;
    logic        prev_reg;
    logic [6:0]  hist_reg;   // seven previous flags; with t they form the 8-flag window
    logic [5:0]  cnt_reg;
    logic [1:0]  type_reg;
    logic [26:0] data_reg;   // slots 4..30, first-received slot ends in bit 0
    logic [3:0]  lock_reg;

    logic        t;
    logic [7:0]  window;
    logic        match;
    logic [1:0]  match_type;
    logic        load;

    assign t      = i_bmc ^ prev_reg;
    assign window = {hist_reg, t};
    assign load   = (state_reg == DATA) && (cnt_reg == LAST_HALF);

    assign o_locked = (lock_reg == LOCK_MAX);

    // Classify the current 8-flag window as B, M, W or nothing.
    always_comb begin
        match      = 1'b0;
        match_type = 2'd0;
        case (window)
            PAT_B: begin match = 1'b1; match_type = 2'd0; end
            PAT_M: begin match = 1'b1; match_type = 2'd1; end
            PAT_W: begin match = 1'b1; match_type = 2'd2; end
            default: begin match = 1'b0; match_type = 2'd0; end
        endcase
    end

    // Track the previous line level and the transition-flag history.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b0;
            hist_reg <= '0;
        end else begin
            prev_reg <= i_bmc;
            hist_reg <= window[6:0];
        end
    end

    // Framing FSM, slot collection, lock tracking and the output handshake.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            state_reg   <= HUNT;
            cnt_reg     <= '0;
            type_reg    <= '0;
            data_reg    <= '0;
            lock_reg    <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_v         <= 1'b0;
            o_u         <= 1'b0;
            o_c         <= 1'b0;
            o_preamble  <= '0;
            o_bmc_error <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_bmc_error <= 1'b0;
            o_overrun   <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            case (state_reg)
                HUNT: begin
                    if (match) begin
                        type_reg  <= match_type;
                        cnt_reg   <= '0;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (!cnt_reg[0] && !t) begin
                        // Missing cell-boundary transition: drop the subframe.
                        o_bmc_error <= 1'b1;
                        lock_reg    <= '0;
                        state_reg   <= HUNT;
                    end else if (load) begin
                        // A new load wins over a same-cycle acceptance.
                        o_valid    <= 1'b1;
                        o_overrun  <= o_valid && !i_ready;
                        o_data     <= data_reg[23:0];
                        o_v        <= data_reg[24];
                        o_u        <= data_reg[25];
                        o_c        <= data_reg[26];
                        o_preamble <= type_reg;
                        if (lock_reg != LOCK_MAX) begin
                            lock_reg <= lock_reg + 4'd1;
                        end
                        cnt_reg   <= '0;
                        state_reg <= SYNC;
                    end else begin
                        if (cnt_reg[0]) begin
                            data_reg <= {t, data_reg[26:1]};
                        end
                        cnt_reg <= cnt_reg + 6'd1;
                    end
                end
                SYNC: begin
                    if (cnt_reg == SYNC_LAST) begin
                        cnt_reg <= '0;
                        if (match) begin
                            type_reg  <= match_type;
                            state_reg <= DATA;
                        end else begin
                            o_bmc_error <= 1'b1;
                            lock_reg    <= '0;
                            state_reg   <= HUNT;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 6'd1;
                    end
                end
                default: begin
                    state_reg <= HUNT;
                end
            endcase
        end
    end

`ifdef SPDIF_DECODER_PARITY_CHECK_EN
    // Even parity over slots 4..31; the P slot is the flag sampled at the load.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            o_parity_error <= 1'b0;
        end else if (load && cnt_reg[0] && t) begin
            o_parity_error <= ^{t, data_reg};
        end else if (load) begin
            o_parity_error <= ^{t, data_reg};
        end
    end
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_bmc_decoder.sv
// Self-checking bench for spdif_bmc_decoder. It builds subframes as
// transition-flag sequences: a preamble, then one boundary flag and one data
// flag per slot. It converts the flags to line levels and compares the
// decoded outputs against the word it sent.
module tb_spdif_bmc_decoder;

    localparam int LOCK_COUNT = 2;

    logic        clk128 = 1'b0;
    logic        reset;
    logic        i_bmc;
    logic        i_ready;
    logic        o_valid;
    logic [23:0] o_data;
    logic        o_v, o_u, o_c;
    logic [1:0]  o_preamble;
    logic        o_parity_error;
    logic        o_bmc_error;
    logic        o_overrun;
    logic        o_locked;

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int ovr_pulses = 0;
    int valid_cycles = 0;
    logic level = 1'b0;

    always #5 clk128 = ~clk128;

    spdif_bmc_decoder #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .clk128(clk128), .reset(reset), .i_bmc(i_bmc), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_v(o_v), .o_u(o_u), .o_c(o_c),
        .o_preamble(o_preamble), .o_parity_error(o_parity_error),
        .o_bmc_error(o_bmc_error), .o_overrun(o_overrun), .o_locked(o_locked)
    );

    // Count cycles during which each pulse/flag output is high.
    always @(posedge clk128) begin
        #1;
        if (o_bmc_error === 1'b1) err_pulses++;
        if (o_overrun === 1'b1) ovr_pulses++;
        if (o_valid === 1'b1) valid_cycles++;
    end

    // Preamble flags, oldest flag in bit 7: B=10011100 M=10010011 W=10010110.
    function automatic logic [7:0] pre_flags(input int p);
        case (p)
            0: return 8'b1001_1100;
            1: return 8'b1001_0011;
            default: return 8'b1001_0110;
        endcase
    endfunction

    // Word layout: [23:0] sample, 24 V, 25 U, 26 C, 27 P (even parity, optionally spoiled).
    function automatic logic [27:0] make_word(input logic [23:0] d, input logic v, input logic u,
                                              input logic c, input logic flip_p);
        logic p;
        p = (^{c, u, v, d}) ^ flip_p;
        return {p, c, u, v, d};
    endfunction

    // One half-cell: a transition flag of 1 toggles the line.
    task automatic half(input logic tf);
        @(negedge clk128);
        level = level ^ tf;
        i_bmc = level;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) half(1'b0);
    endtask

    // Send one subframe. bad_hc: data half-cell whose boundary transition is
    // dropped (-1 none). stop_hc: stop before this half-cell (-1 none).
    // ready_mode: 1 raises i_ready just before the load edge, 2 drops it
    // after the second preamble half-cell.
    task automatic send_subframe(input int pre, input logic [27:0] w, input int bad_hc,
                                 input int stop_hc, input int ready_mode);
        logic [7:0] pf;
        logic       tf;
        pf = pre_flags(pre);
        for (int i = 0; i < 8; i++) begin
            half(pf[7-i]);
            if (ready_mode == 2 && i == 1) i_ready = 1'b0;
        end
        for (int hc = 0; hc < 56; hc++) begin
            if (hc == stop_hc) return;
            if (hc % 2 == 0) tf = (hc == bad_hc) ? 1'b0 : 1'b1;
            else tf = w[hc/2];
            half(tf);
            if (hc == 55 && ready_mode == 1) i_ready = 1'b1;
        end
        @(posedge clk128);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_ready = 1'b1;
        i_bmc = 1'b0;
        repeat (3) @(negedge clk128);
        n_cmp++;
        if ({o_valid, o_data, o_v, o_u, o_c, o_preamble, o_parity_error, o_bmc_error, o_overrun, o_locked} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h locked=%b err=%b ovr=%b, need all 0",
                     o_valid, o_data, o_locked, o_bmc_error, o_overrun);
        end
        reset = 1'b0;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_clean;
        logic [27:0] w;
        int v0;
        w = make_word(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        v0 = valid_cycles;
        send_subframe(0, w, -1, -1, 0);
        $display("clean: data=%h pre=%0d vuc=%b%b%b par=%b locked=%b", o_data, o_preamble, o_v, o_u, o_c, o_parity_error, o_locked);
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid: got %b need 1", o_valid); end
        n_cmp++; if (o_data !== 24'h123456) begin n_bad++; $display("FAIL clean_data: got %h need 123456", o_data); end
        n_cmp++; if (o_preamble !== 2'd0) begin n_bad++; $display("FAIL clean_pre: got %0d need 0", o_preamble); end
        n_cmp++; if ({o_v, o_u, o_c} !== 3'b010) begin n_bad++; $display("FAIL clean_vuc: got %b%b%b need 010", o_v, o_u, o_c); end
        n_cmp++; if (o_parity_error !== 1'b0) begin n_bad++; $display("FAIL clean_parity: got %b need 0", o_parity_error); end
        n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL clean_locked: got %b need 0", o_locked); end
        n_cmp++; if (valid_cycles - v0 !== 1) begin n_bad++; $display("FAIL clean_valid_len: got %0d need 1", valid_cycles - v0); end
    endtask

    task automatic test_polarity;
        logic [27:0] w;
        logic [23:0] d;
        reset = 1'b1;
        @(negedge clk128);
        reset = 1'b0;
        level = 1'b1;
        i_bmc = 1'b1;
        idle(4);
        w = make_word(24'h123456, 1'b0, 1'b1, 1'b0, 1'b0);
        send_subframe(0, w, -1, -1, 0);
        $display("polarity: data=%h pre=%0d locked=%b", o_data, o_preamble, o_locked);
        n_cmp++; if (o_data !== 24'h123456 || {o_v, o_u, o_c} !== 3'b010 || o_preamble !== 2'd0)
            begin n_bad++; $display("FAIL pol_frame: got %h/%b%b%b/%0d need 123456/010/0", o_data, o_v, o_u, o_c, o_preamble); end
        n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL pol_locked1: got %b need 0", o_locked); end
        d = 24'($urandom);
        w = make_word(d, 1'b1, 1'b0, 1'b1, 1'b0);
        send_subframe(1, w, -1, -1, 0);
        $display("polarity 2nd: data=%h pre=%0d locked=%b", o_data, o_preamble, o_locked);
        n_cmp++; if (o_data !== d || o_preamble !== 2'd1) begin n_bad++; $display("FAIL pol_frame2: got %h/%0d need %h/1", o_data, o_preamble, d); end
        n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL pol_locked2: got %b need 1", o_locked); end
    endtask

    task automatic test_bmc_error;
        logic [27:0] w;
        int e0, v0;
        e0 = err_pulses;
        v0 = valid_cycles;
        w = make_word(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        send_subframe(2, w, 20, -1, 0);
        $display("bmc error frame: err_cycles=%0d valid_cycles=%0d locked=%b", err_pulses - e0, valid_cycles - v0, o_locked);
        n_cmp++; if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL err_pulse: got %0d cycles need 1", err_pulses - e0); end
        n_cmp++; if (valid_cycles - v0 !== 0) begin n_bad++; $display("FAIL err_novalid: got %0d cycles need 0", valid_cycles - v0); end
        n_cmp++; if (o_locked !== 1'b0) begin n_bad++; $display("FAIL err_locked: got %b need 0", o_locked); end
        w = make_word(24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0);
        e0 = err_pulses;
        send_subframe(2, w, -1, -1, 0);
        $display("recovery: data=%h pre=%0d locked=%b", o_data, o_preamble, o_locked);
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 24'hABCDEF || o_preamble !== 2'd2)
            begin n_bad++; $display("FAIL err_recover: got %b/%h/%0d need 1/abcdef/2", o_valid, o_data, o_preamble); end
        n_cmp++; if (o_locked !== 1'b0 || err_pulses != e0) begin n_bad++; $display("FAIL err_relock: got locked=%b errs=%0d need 0/0", o_locked, err_pulses - e0); end
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ovr_pulses;
        send_subframe(0, make_word(24'h000001, 1'b0, 1'b0, 1'b0, 1'b0), -1, -1, 2);
        $display("overrun 1st: data=%h valid=%b ovr=%0d", o_data, o_valid, ovr_pulses - o0);
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 24'h000001 || ovr_pulses != o0)
            begin n_bad++; $display("FAIL ovr_first: got %b/%h/%0d need 1/000001/0", o_valid, o_data, ovr_pulses - o0); end
        send_subframe(1, make_word(24'h000002, 1'b0, 1'b0, 1'b0, 1'b0), -1, -1, 0);
        $display("overrun 2nd: data=%h valid=%b ovr=%0d", o_data, o_valid, ovr_pulses - o0);
        n_cmp++; if (ovr_pulses - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d need 1", ovr_pulses - o0); end
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 24'h000002) begin n_bad++; $display("FAIL ovr_data: got %b/%h need 1/000002", o_valid, o_data); end
        o0 = ovr_pulses;
        send_subframe(2, make_word(24'h000003, 1'b0, 1'b0, 1'b0, 1'b0), -1, -1, 1);
        $display("ready at load: data=%h valid=%b ovr=%0d", o_data, o_valid, ovr_pulses - o0);
        n_cmp++; if (ovr_pulses != o0) begin n_bad++; $display("FAIL ovr_ready_load: got %0d pulses need 0", ovr_pulses - o0); end
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 24'h000003) begin n_bad++; $display("FAIL ovr_ready_data: got %b/%h need 1/000003", o_valid, o_data); end
    endtask

    task automatic test_parity;
        logic [23:0] d;
        logic        exp_par;
        int          v0;
`ifdef SPDIF_DECODER_PARITY_CHECK_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        d = 24'($urandom);
        v0 = valid_cycles;
        send_subframe(0, make_word(d, 1'b1, 1'b0, 1'b0, 1'b1), -1, -1, 0);
        $display("parity flipped: data=%h par=%b", o_data, o_parity_error);
        n_cmp++; if (valid_cycles - v0 !== 1) begin n_bad++; $display("FAIL par_valid_len: got %0d need 1", valid_cycles - v0); end
        n_cmp++; if (o_parity_error !== exp_par) begin n_bad++; $display("FAIL par_flag: got %b need %b", o_parity_error, exp_par); end
        n_cmp++; if (o_data !== d || o_v !== 1'b1) begin n_bad++; $display("FAIL par_data: got %h/%b need %h/1", o_data, o_v, d); end
        d = 24'($urandom);
        send_subframe(1, make_word(d, 1'b1, 1'b0, 1'b0, 1'b0), -1, -1, 0);
        $display("parity good: data=%h par=%b", o_data, o_parity_error);
        n_cmp++; if (o_parity_error !== 1'b0 || o_data !== d) begin n_bad++; $display("FAIL par_clear: got %b/%h need 0/%h", o_parity_error, o_data, d); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] d;
        logic [2:0]  vuc;
        int          p, e0;
        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(0, 2);
            d = 24'($urandom);
            vuc = 3'($urandom);
            e0 = err_pulses;
            send_subframe(p, make_word(d, vuc[0], vuc[1], vuc[2], 1'b0), -1, -1, 0);
            $display("b2b %0d: pre=%0d data=%h vuc=%b%b%b locked=%b", k, o_preamble, o_data, o_v, o_u, o_c, o_locked);
            n_cmp++; if (o_valid !== 1'b1 || o_data !== d) begin n_bad++; $display("FAIL b2b_data %0d: got %b/%h need 1/%h", k, o_valid, o_data, d); end
            n_cmp++; if ({o_c, o_u, o_v} !== vuc || o_preamble !== 2'(p)) begin n_bad++; $display("FAIL b2b_fields %0d: got cuv=%b%b%b pre=%0d need %b/%0d", k, o_c, o_u, o_v, o_preamble, vuc, p); end
            n_cmp++; if (o_parity_error !== 1'b0 || err_pulses != e0) begin n_bad++; $display("FAIL b2b_errs %0d: got par=%b errs=%0d need 0/0", k, o_parity_error, err_pulses - e0); end
        end
        n_cmp++; if (o_locked !== 1'b1) begin n_bad++; $display("FAIL b2b_locked: got %b need 1", o_locked); end
    endtask

    task automatic test_reset_mid;
        logic [23:0] d;
        send_subframe(0, make_word(24'h55AA55, 1'b0, 1'b0, 1'b0, 1'b0), -1, 30, 0);
        @(negedge clk128);
        reset = 1'b1;
        #2;
        $display("reset mid-frame: valid=%b data=%h locked=%b", o_valid, o_data, o_locked);
        n_cmp++;
        if ({o_valid, o_data, o_v, o_u, o_c, o_preamble, o_parity_error, o_bmc_error, o_overrun, o_locked} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got valid=%b data=%h locked=%b, need all 0", o_valid, o_data, o_locked);
        end
        repeat (2) @(negedge clk128);
        reset = 1'b0;
        idle(3);
        d = 24'($urandom);
        send_subframe(1, make_word(d, 1'b0, 1'b1, 1'b1, 1'b0), -1, -1, 0);
        $display("after reset: data=%h pre=%0d locked=%b", o_data, o_preamble, o_locked);
        n_cmp++; if (o_valid !== 1'b1 || o_data !== d || o_preamble !== 2'd1) begin n_bad++; $display("FAIL reset_mid_decode: got %b/%h/%0d need 1/%h/1", o_valid, o_data, o_preamble, d); end
        n_cmp++; if ({o_v, o_u, o_c} !== 3'b011 || o_locked !== 1'b0) begin n_bad++; $display("FAIL reset_mid_fields: got vuc=%b%b%b locked=%b need 011/0", o_v, o_u, o_c, o_locked); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_polarity();
        test_bmc_error();
        test_overrun();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, need completion");
        $fatal(1, "timeout");
    end

endmodule
